// File: rtl/sram_load_ctrl.sv
// Streams the CNN image and weight words from external SRAM into the on-chip buffer.
// Each word takes one REQ phase (held until rvalid) plus one WRITE cycle, so 2 cycles/word at zero SRAM latency.
// One outstanding read; optional REQ wait timeout enabled by defining SRAM_LOAD_TIMEOUT_EN.
module sram_load_ctrl #(
  parameter int unsigned           ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]     IMG_BASE    = 16'h0000,
  parameter logic [ADDR_W-1:0]     WGT_BASE    = 16'h0100,
  parameter int unsigned           IMG_WORDS   = 32,
  parameter int unsigned           WGT_WORDS   = 512,
  parameter int unsigned           TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              wgt_only,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_rvalid,
  output logic              buf_we,
  output logic              buf_is_wgt,
  output logic [8:0]        buf_idx,
  output logic [31:0]       buf_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [8:0] IMG_LAST = 9'(IMG_WORDS - 1);
  localparam logic [8:0] WGT_LAST = 9'(WGT_WORDS - 1);

  logic [1:0]  state;
  logic        phase;     // 0 = image, 1 = weight
  logic [8:0]  cnt;       // word index within the current phase
  logic [31:0] data_q;    // word captured on rvalid
  logic        last_word;
  logic        timeout;

  // Phase-end compare happens before any increment, so the 9-bit counter never wraps.
  assign last_word = phase ? (cnt == WGT_LAST) : (cnt == IMG_LAST);

`ifdef SRAM_LOAD_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout = (wait_cnt == 8'(TIMEOUT_CYC - 1));

  // Wait counter: zero whenever outside REQ, so every REQ entry starts from 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt <= '0;
    end else if (state == S_REQ && !sram_rvalid) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error: set on a REQ timeout, cleared only by the next accepted start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (state == S_REQ && !sram_rvalid && timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Main sequencer: request, capture, write, advance; image phase then weight phase.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= S_IDLE;
      phase  <= 1'b0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            phase <= wgt_only;
            cnt   <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          // rvalid takes priority over a simultaneous timeout.
          if (sram_rvalid) begin
            data_q <= sram_rdata;
            state  <= S_WRITE;
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (last_word) begin
            if (!phase) begin
              phase <= 1'b1;
              cnt   <= '0;
              state <= S_REQ;
            end else begin
              state <= S_DONE;
            end
          end else begin
            cnt   <= cnt + 9'd1;
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs are decoded from registered state only; idle values are zero.
  assign sram_rd    = (state == S_REQ);
  assign sram_addr  = (state == S_REQ) ? ((phase ? WGT_BASE : IMG_BASE) + ADDR_W'(cnt)) : '0;
  assign buf_we     = (state == S_WRITE);
  assign buf_is_wgt = (state == S_WRITE) && phase;
  assign buf_idx    = (state == S_WRITE) ? cnt : '0;
  assign buf_wdata  = (state == S_WRITE) ? data_q : '0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule

// File: doc/sram_load_ctrl.md
# sram_load_ctrl

Sequencer that fetches the CNN input image and weight set from external SRAM and streams them into the SRAM buffer. On a start pulse it issues one 32-bit read per word, waits for the SRAM read-valid handshake, and forwards each word as a single buffer write tagged image or weight with its word index. It sits between the top-level control FSM, which asserts start and waits for done, and the SRAM interface/buffer pair.

## Interface
Parameters:
- ADDR_W, 16, SRAM word-address width
- IMG_BASE, 16'h0000, SRAM word address of image word 0
- WGT_BASE, 16'h0100, SRAM word address of weight word 0
- IMG_WORDS, 32, image words (64 × 16-bit elements)
- WGT_WORDS, 512, weight words (1024 × 16-bit elements)
- TIMEOUT_CYC, 255, max cycles in REQ without rvalid (SRAM_LOAD_TIMEOUT_EN only)

Ports (reset n_rst, asynchronous, active-low; clock clk):
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle load request; sampled in IDLE only
- wgt_only  in  1  sampled with start; 1 = skip image phase
- sram_rd  out  1  read request, held until rvalid
- sram_addr  out  ADDR_W  word address of current request
- sram_rdata  in  32  read data, valid with sram_rvalid
- sram_rvalid  in  1  read data valid
- buf_we  out  1  one-cycle buffer write strobe
- buf_is_wgt  out  1  0 = image array, 1 = weight array
- buf_idx  out  9  word index within current array
- buf_wdata  out  32  [15:0] = element 2·idx, [31:16] = element 2·idx+1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky timeout flag; tied 0 without macro

## Operation
- States: IDLE, REQ, WRITE, DONE.
- IDLE: start=1 → latch phase (wgt_only ? WGT : IMG), clear word counter, → REQ.
- REQ: sram_rd=1, sram_addr = base(phase) + cnt. sram_rvalid=1 → register sram_rdata, → WRITE.
- WRITE: buf_we=1, buf_is_wgt=phase, buf_idx=cnt, buf_wdata=registered data. If cnt = last word of phase: IMG → switch to WGT, cnt=0, → REQ; WGT → DONE. Otherwise cnt+1, → REQ.
- DONE: done=1 for one cycle, → IDLE.
- sram_rvalid outside REQ is ignored. start outside IDLE is ignored.
- One outstanding read maximum; addresses strictly increment by 1 within a phase.
- Counter is 9 bits; never wraps, since the phase-end compare precedes increment.
- The controller never clears buffer contents; wgt_only keeps the prior image.

## Timing
- Reset values: sram_rd=0, sram_addr=0, buf_we=0, buf_is_wgt=0, buf_idx=0, buf_wdata=0, busy=0, done=0, err=0; state IDLE.
- start at cycle t → REQ at t+1, sram_rd high from t+1.
- rvalid sampled at cycle r → buf_we at r+1; next sram_rd at r+2 (one-cycle gap).
- Zero-latency SRAM: 2 cycles/word; full load (544 words) → done at t+1089.
- All outputs are registered or decoded from registered state; no combinational input→output path.
- Reset mid-operation → immediate IDLE with all reset values; partial buffer contents stay; no done is generated.

## Configuration
- SRAM_LOAD_TIMEOUT_EN defined: an 8-bit wait counter clears on REQ entry and increments each REQ cycle. Reaching TIMEOUT_CYC without rvalid drops sram_rd, sets err=1, and returns to IDLE with no done. err clears on the next accepted start. If rvalid and the timeout occur in the same cycle, rvalid wins.
- Undefined: no wait counter; REQ waits indefinitely; err is constant 0.

## Test plan
- Full load, rvalid same cycle as sram_rd, rdata = {addr+1, addr}: expect 32 image writes with idx 0–31 and addr 0x0000–0x001F, then 512 weight writes with idx 0–511 and addr 0x0100–0x02FF; done at t+1089; busy low at t+1090.
- wgt_only=1 with start: no write has buf_is_wgt=0; first sram_addr = 0x0100; done after 1024 cycles + 1.
- rvalid latency 3: sram_rd held high 4 cycles per word; buf_wdata matches each addressed word; no dropped or duplicated idx.
- start pulsed mid-load, plus a spurious rvalid during WRITE: no restart, no extra buf_we; total write count remains 544.
- n_rst asserted at weight word 100: all outputs 0 in the same cycle; no done; a fresh start reloads from image word 0.
- SRAM_LOAD_TIMEOUT_EN, rvalid withheld at image word 5: after 255 REQ cycles sram_rd=0, err=1, done=0, busy=0; next start clears err and completes normally.
